// File: rtl/matmul_mxnxl.sv
// Registered unsigned matrix product R = G*g (M x N times N x L), truncated to W bits per element.
// One dot-product instance per result element; the whole product settles combinationally each cycle.

module matmul_dot #(
    parameter int W = 8,
    parameter int N = 3
) (
    input  logic [N-1:0][W-1:0] row,
    input  logic [N-1:0][W-1:0] col,
    output logic [W-1:0]        dot
);
    localparam int ACC_W = 2*W + $clog2(N);

    logic [ACC_W-1:0] acc;
    logic             unused_hi;

    always_comb begin
        acc = '0;
        for (int k = 0; k < N; k++)
            acc = acc + ACC_W'(row[k]) * ACC_W'(col[k]);
    end

    // Result wraps modulo 2^W; the upper accumulator bits are intentionally dropped.
    assign dot       = acc[W-1:0];
    assign unused_hi = ^acc[ACC_W-1:W];
endmodule

module matmul_mxnxl #(
    parameter int W = 8,
    parameter int M = 4,
    parameter int N = 3,
    parameter int L = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [M*N*W-1:0] transformation_mtx,
    input  logic [N*L*W-1:0] input_mtx,
    output logic [M*L*W-1:0] result_mtx
);
    // Flat element views; element [r][c] of an R x C matrix sits at index R*C-1-(r*C+c).
    logic [M*N-1:0][W-1:0] g_el;
    logic [N*L-1:0][W-1:0] x_el;
    logic [M*L-1:0][W-1:0] res_d, res_q;

    assign g_el = transformation_mtx;
    assign x_el = input_mtx;

    for (genvar i = 0; i < M; i++) begin : g_row
        for (genvar j = 0; j < L; j++) begin : g_col
            logic [N-1:0][W-1:0] row, col;
            for (genvar k = 0; k < N; k++) begin : g_k
                assign row[k] = g_el[M*N-1-(i*N+k)];
                assign col[k] = x_el[N*L-1-(k*L+j)];
            end
            matmul_dot #(.W(W), .N(N)) u_dot (
                .row (row),
                .col (col),
                .dot (res_d[M*L-1-(i*L+j)])
            );
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) res_q <= '0;
        else       res_q <= res_d;
    end

    assign result_mtx = res_q;
endmodule

// File: tb/tb_matmul_mxnxl.sv
// Randomized self-checking bench for matmul_mxnxl against an array-based reference product.

module tb_matmul_mxnxl;
    localparam int W = 8, M = 4, N = 3, L = 3;
    localparam int GW = M*N*W, XW = N*L*W, RW = M*L*W;

    logic          clk = 1'b0;
    logic          rstn;
    logic [GW-1:0] gm;
    logic [XW-1:0] xm;
    logic [RW-1:0] rm;

    int checks = 0;
    int errors = 0;

    matmul_mxnxl #(.W(W), .M(M), .N(N), .L(L)) dut (
        .clk                (clk),
        .rstn               (rstn),
        .transformation_mtx (gm),
        .input_mtx          (xm),
        .result_mtx         (rm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Reference: unpack to 2-D integer arrays, multiply with plain integer math, repack.
    function automatic logic [RW-1:0] model(input logic [GW-1:0] g, input logic [XW-1:0] x);
        int unsigned ga [M][N];
        int unsigned xa [N][L];
        int unsigned s;
        logic [RW-1:0] r;
        for (int i = 0; i < M; i++)
            for (int k = 0; k < N; k++)
                ga[i][k] = int'(g[(M*N-1-(i*N+k))*W +: W]);
        for (int k = 0; k < N; k++)
            for (int j = 0; j < L; j++)
                xa[k][j] = int'(x[(N*L-1-(k*L+j))*W +: W]);
        r = '0;
        for (int i = 0; i < M; i++)
            for (int j = 0; j < L; j++) begin
                s = 0;
                for (int k = 0; k < N; k++) s = s + ga[i][k] * xa[k][j];
                r[(M*L-1-(i*L+j))*W +: W] = W'(s % (1 << W));
            end
        return r;
    endfunction

    function automatic logic [GW-1:0] rnd_g();
        logic [GW-1:0] v;
        v = {$urandom, $urandom, $urandom};
        return v;
    endfunction

    function automatic logic [XW-1:0] rnd_x();
        logic [95:0] v;
        v = {$urandom, $urandom, $urandom};
        return v[XW-1:0];
    endfunction

    logic [RW-1:0] exp_r;

    initial begin
        rstn = 1'b0;
        gm   = 96'h0102030405060708090A0B0C;
        xm   = 72'h010203040506070809;

        // Reset held with clock running
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("reset_hold", rm, '0);
        end

        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
        chk("nominal_const", rm, 96'h1E242A_425160_667E96_8AABCC);
        chk("nominal_model", rm, model(gm, xm));

        @(negedge clk);
        gm = '1;
        xm = '1;
        @(posedge clk); #1;
        chk("trunc_ff", rm, {12{8'h03}});

        @(negedge clk);
        gm = 96'h010000_000100_000001_000000;
        xm = 72'h010203040506070809;
        @(posedge clk); #1;
        chk("identity", rm, 96'h010203_040506_070809_000000);

        // Per-cycle random inputs with a mid-cycle glitch between edges
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            gm = rnd_g();
            xm = rnd_x();
            exp_r = model(gm, xm);
            @(posedge clk); #1;
            chk("rand_track", rm, exp_r);
            gm = rnd_g();
            xm = rnd_x();
            #2;
            chk("rand_glitch_hold", rm, exp_r);
        end

        // Async reset between edges
        @(negedge clk);
        gm = 96'h0102030405060708090A0B0C;
        xm = 72'h010203040506070809;
        @(posedge clk); #1;
        chk("pre_async", rm, 96'h1E242A_425160_667E96_8AABCC);
        #2 rstn = 1'b0;
        #1;
        chk("async_clear", rm, '0);
        @(posedge clk); #1;
        chk("async_hold", rm, '0);

        @(negedge clk);
        rstn = 1'b1;
        gm   = rnd_g();
        xm   = rnd_x();
        exp_r = model(gm, xm);
        @(posedge clk); #1;
        chk("first_after_reset", rm, exp_r);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
